// File: rtl/i8008_pkg.sv
// Shared types for the i8008 external bus: core state encoding (S0..S2),
// cycle-control field carried on D7:D6 at T2, and the RST instruction helper.
package i8008_pkg;

  typedef enum logic [2:0] {
    WAIT    = 3'b000,
    T2      = 3'b001,
    T1      = 3'b010,
    T1I     = 3'b011,
    T3      = 3'b100,
    T5      = 3'b101,
    STOPPED = 3'b110,
    T4      = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    PCI = 2'b00,  // instruction fetch
    PCR = 2'b01,  // memory read
    PCC = 2'b10,  // I/O command
    PCW = 2'b11   // memory write
  } cycle_ctrl_t;

  // First output port number; output ports occupy IO_OUT_BASE..31.
  localparam int IO_OUT_BASE = 8;
  localparam int N_OUT_PORTS = 24;

  // Encoding of the one-byte RST n instruction (00 nnn 101).
  function automatic logic [7:0] RST_INSTR(input logic [2:0] n);
    return {2'b00, n, 3'b101};
  endfunction

endpackage

// File: rtl/i8008_bus_mem.sv
// Byte-wide program/data memory for the bus controller.
// Two write ports (load port wins on a same-address collision) and one
// asynchronous read port whose result the controller registers at T2.
module i8008_bus_mem
  import i8008_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  // Bus write first, load write last so the load takes precedence.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i8008_bus_ctrl.sv
// Memory, I/O and interrupt controller on the i8008 external bus.
// Decode-only: all sequencing comes from the core's state input.
// Optional feature macro: I8008_BUS_IO_EN enables PCC port decode and the
// output port registers; without it PCC reads return 0 and writes drop.
//
//   state   | meaning
//   T1      | low address byte on D_out
//   T1I     | low address byte, interrupt acknowledge cycle
//   T2      | cycle type + high address on D_out, read data registered
//   WAIT    | core stalled until READY
//   T3      | data phase; writes commit at the closing edge
//   STOPPED | halted; only INTR can change
//   T4/T5   | internal core states, no bus action
module i8008_bus_ctrl
  import i8008_pkg::*;
#(
  parameter int          ADDR_W      = 14,
  parameter int          WAIT_STATES = 0,
  parameter logic [7:0]  IRQ_VECTOR  = RST_INSTR(3'd0),
  parameter int          N_IN        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  state_t                     state,
  input  logic                       Sync,
  input  logic [7:0]                 D_out,
  output logic [7:0]                 D_in,
  output logic                       READY,
  output logic                       INTR,
  input  logic                       irq_req,
  input  logic                       ld_en,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [7:0]                 ld_data,
  input  logic [N_IN*8-1:0]          in_ports,
  output logic [N_OUT_PORTS*8-1:0]   out_ports,
  output logic                       out_stb
);

  logic [7:0]  addr_lo;
  logic [5:0]  addr_hi;
  cycle_ctrl_t cyc;
  cycle_ctrl_t t2_cyc;
  logic        irq_ack;
  logic [3:0]  wait_cnt;
  logic        wait_done;
  logic        is_t1, is_t1i, is_t2, is_wait, is_t3;
  logic [13:0] rd_addr_full;
  logic [13:0] wr_addr_full;
  logic [7:0]  mem_rd_data;
  logic [7:0]  io_rd_data;
  logic [7:0]  rd_data_next;
  logic        mem_we;

  // Decode the core state into per-phase strobes.
  always_comb begin
    is_t1   = 1'b0;
    is_t1i  = 1'b0;
    is_t2   = 1'b0;
    is_wait = 1'b0;
    is_t3   = 1'b0;
    case (state)
      T1:      is_t1   = 1'b1;
      T1I:     is_t1i  = 1'b1;
      T2:      is_t2   = 1'b1;
      WAIT:    is_wait = 1'b1;
      T3:      is_t3   = 1'b1;
      default: ;
    endcase
  end

  assign t2_cyc       = cycle_ctrl_t'(D_out[7:6]);
  assign rd_addr_full = {D_out[5:0], addr_lo};
  assign wr_addr_full = {addr_hi, addr_lo};
  assign mem_we       = !rst && is_t3 && (cyc == PCW);

  // wait_cnt counts clocks already spent in T2/WAIT of this cycle, so it
  // is zero throughout T2 and equals k during the k-th WAIT.
  assign wait_done = (wait_cnt == 4'(WAIT_STATES));
  assign READY     = !rst && (is_t2 || is_wait) && wait_done;

  i8008_bus_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wr_en   (mem_we),
    .wr_addr (wr_addr_full[ADDR_W-1:0]),
    .wr_data (D_out),
    .rd_addr (rd_addr_full[ADDR_W-1:0]),
    .rd_data (mem_rd_data)
  );

  // Select what the core will see in T3, based on the cycle type seen at T2.
  always_comb begin
    rd_data_next = mem_rd_data;
    case (t2_cyc)
      PCI:     rd_data_next = irq_ack ? IRQ_VECTOR : mem_rd_data;
      PCR:     rd_data_next = mem_rd_data;
      PCC:     rd_data_next = io_rd_data;
      PCW:     rd_data_next = mem_rd_data;
      default: rd_data_next = mem_rd_data;
    endcase
  end

  // Address/cycle latches, read data register, wait counter, irq_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lo  <= 8'h00;
      addr_hi  <= 6'h00;
      cyc      <= PCI;
      D_in     <= 8'h00;
      wait_cnt <= 4'd0;
      irq_ack  <= 1'b0;
    end else begin
      if (is_t1 || is_t1i) begin
        addr_lo  <= D_out;
        wait_cnt <= 4'd0;
      end
      if (is_t1i) irq_ack <= 1'b1;
      if (is_t2) begin
        cyc     <= t2_cyc;
        addr_hi <= D_out[5:0];
        D_in    <= rd_data_next;
      end
      if ((is_t2 || is_wait) && !wait_done) wait_cnt <= wait_cnt + 4'd1;
      if (is_t3) irq_ack <= 1'b0;
    end
  end

  // Interrupt request latch; a new request beats a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst)          INTR <= 1'b0;
    else if (irq_req) INTR <= 1'b1;
    else if (is_t1i)  INTR <= 1'b0;
  end

`ifdef I8008_BUS_IO_EN
  logic [4:0] port;

  // Input port read mux; ports between N_IN and the output range read 0.
  always_comb begin
    io_rd_data = 8'h00;
    for (int i = 0; i < N_IN; i++) begin
      if (i < IO_OUT_BASE && D_out[5:1] == 5'(i)) io_rd_data = in_ports[i*8 +: 8];
    end
  end

  // Port latch at T2; output port write and strobe at the edge ending T3.
  always_ff @(posedge clk) begin
    if (rst) begin
      port      <= 5'd0;
      out_ports <= '0;
      out_stb   <= 1'b0;
    end else begin
      out_stb <= 1'b0;
      if (is_t2) port <= D_out[5:1];
      if (is_t3 && cyc == PCC && port >= 5'(IO_OUT_BASE)) begin
        out_stb <= 1'b1;
        for (int i = 0; i < N_OUT_PORTS; i++) begin
          if (port == 5'(i + IO_OUT_BASE)) out_ports[i*8 +: 8] <= addr_lo;
        end
      end
    end
  end
`else
  logic unused_io;

  assign io_rd_data = 8'h00;
  assign out_ports  = '0;
  assign out_stb    = 1'b0;
  assign unused_io  = ^in_ports;
`endif

  logic unused_bits;
  assign unused_bits = ^{Sync, rd_addr_full, wr_addr_full};

endmodule

// File: tb/tb_i8008_bus_ctrl.sv
// Directed bench for i8008_bus_ctrl. The bench plays the core's side of the
// bus. dut0: ADDR_W=14, WAIT_STATES=0, N_IN=4. dut1: ADDR_W=10,
// WAIT_STATES=3, N_IN=8. Expected I/O values follow I8008_BUS_IO_EN.
module tb_i8008_bus_ctrl;
  import i8008_pkg::*;

`ifdef I8008_BUS_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, sync, irq_req, ld_en;
  logic [13:0]       ld_addr;
  logic [7:0]        ld_data;
  logic [1:0][2:0]   st;
  logic [1:0][7:0]   dout;
  logic [1:0][7:0]   din;
  logic [1:0]        rdy, intr, stbw;
  logic [1:0][191:0] outp;
  logic [31:0]       inp0;
  logic [63:0]       inp1;

  int n_checks = 0;
  int n_fail   = 0;

  i8008_bus_ctrl #(.ADDR_W(14), .WAIT_STATES(0), .N_IN(4)) dut0 (
    .clk(clk), .rst(rst), .state(state_t'(st[0])), .Sync(sync), .D_out(dout[0]),
    .D_in(din[0]), .READY(rdy[0]), .INTR(intr[0]), .irq_req(irq_req),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .in_ports(inp0),
    .out_ports(outp[0]), .out_stb(stbw[0])
  );

  i8008_bus_ctrl #(.ADDR_W(10), .WAIT_STATES(WS1), .N_IN(8)) dut1 (
    .clk(clk), .rst(rst), .state(state_t'(st[1])), .Sync(sync), .D_out(dout[1]),
    .D_in(din[1]), .READY(rdy[1]), .INTR(intr[1]), .irq_req(irq_req),
    .ld_en(ld_en), .ld_addr(ld_addr[9:0]), .ld_data(ld_data), .in_ports(inp1),
    .out_ports(outp[1]), .out_stb(stbw[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [13:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // One bus cycle on dut s: T1/T1I, T2, WAIT until READY, T3, T4, idle.
  task automatic bus_cycle(input int s, input logic [2:0] t1, input logic [7:0] lo,
                           input logic [7:0] ctl, input logic [7:0] wdata,
                           input bit ld3, input logic [13:0] la, input logic [7:0] ldd,
                           output logic [7:0] rdata, output int waits,
                           output logic [1:0] stb, output logic intr_t2);
    logic       r;
    logic [7:0] held;
    waits = 0;
    held  = 8'h00;
    @(posedge clk); #1; st[s] = t1; dout[s] = lo;
    @(posedge clk); #1; st[s] = T2; dout[s] = ctl;
    @(negedge clk); r = rdy[s]; intr_t2 = intr[s];
    while (!r) begin
      @(posedge clk); #1; st[s] = WAIT;
      @(negedge clk); r = rdy[s];
      if (waits == 0) held = din[s];
      else chk("din_hold_wait", din[s], held);
      waits++;
      if (waits > 20) begin
        chk("wait_bound", waits, 20);
        r = 1'b1;
      end
    end
    @(posedge clk); #1; st[s] = T3; dout[s] = wdata;
    if (ld3) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
    @(negedge clk); rdata = din[s];
    if (waits > 0) chk("din_hold_t3", din[s], held);
    @(posedge clk); #1; ld_en = 1'b0; st[s] = T4; dout[s] = 8'h00;
    @(negedge clk); stb[0] = stbw[s];
    @(posedge clk); #1; st[s] = STOPPED;
    @(negedge clk); stb[1] = stbw[s];
  endtask

  logic [7:0] prog [9] = '{8'h06, 8'h12, 8'h04, 8'h34, 8'h0A, 8'h04, 8'h01, 8'h0A, 8'hFF};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int         w;
    logic [1:0] stb;
    logic       it;

    rst = 1'b1; sync = 1'b0; irq_req = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    st[0] = T2; st[1] = T2; dout = '0;
    inp0 = {8'h00, 8'hC3, 8'h11, 8'h22};
    inp1 = {8'h7E, 56'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", rdy[s], 0);
      chk("rst_din", din[s], 0);
      chk("rst_intr", intr[s], 0);
      chk("rst_stb", stbw[s], 0);
      chk("rst_outp", |outp[s], 0);
    end
    @(posedge clk); #1; st[0] = STOPPED; st[1] = STOPPED;
    for (int i = 0; i < 9; i++) load(14'(i), prog[i]);
    @(posedge clk); #1; rst = 1'b0;

    // instruction fetches, 0 and 3 wait states
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 9; i++) begin
        bus_cycle(s, T1, 8'(i), 8'h00, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
        chk("fetch_data", rd, prog[i]);
        chk("fetch_waits", w, (s == 0) ? 0 : WS1);
      end
    end

    // top-of-memory write/readback and ADDR_W=10 aliasing
    load(14'h3FFF, 8'h55);
    bus_cycle(0, T1, 8'hFF, 8'h7F, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("rd_3fff", rd, 8'h55);
    bus_cycle(1, T1, 8'hFF, 8'h7F, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("alias_rd", rd, 8'h55);
    bus_cycle(0, T1, 8'hFF, 8'hFF, 8'hA7, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("pcw_no_stb", stb, 2'b00);
    bus_cycle(0, T1, 8'hFF, 8'h7F, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("wr_rd_3fff", rd, 8'hA7);
    bus_cycle(1, T1, 8'hFF, 8'hFF, 8'h66, 0, 14'h0, 8'h0, rd, w, stb, it);
    bus_cycle(1, T1, 8'hFF, 8'h43, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("alias_wr_03ff", rd, 8'h66);

    // I/O: OUT port 9, INP port 2, gap port 6, dut1 port 7
    bus_cycle(0, T1, 8'h5A, 8'h92, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("out_port9", outp[0][15:8], IO_EN ? 8'h5A : 8'h00);
    chk("out_other", |{outp[0][191:16], outp[0][7:0]}, 0);
    chk("out_stb_pulse", stb[0], IO_EN);
    chk("out_stb_drop", stb[1], 0);
    bus_cycle(0, T1, 8'h00, 8'h84, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("inp_port2", rd, IO_EN ? 8'hC3 : 8'h00);
    chk("inp_no_stb", stb, 2'b00);
    bus_cycle(0, T1, 8'h00, 8'h8C, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("inp_gap6", rd, 8'h00);
    bus_cycle(1, T1, 8'h00, 8'h8E, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("inp_port7", rd, IO_EN ? 8'h7E : 8'h00);

    // interrupt from STOPPED, merged second request, vector fetch
    @(negedge clk);
    chk("intr_idle", intr[0], 0);
    @(posedge clk); #1; irq_req = 1'b1;
    @(posedge clk); #1; irq_req = 1'b0;
    @(negedge clk);
    chk("intr_rise", intr[0], 1);
    @(posedge clk); #1; irq_req = 1'b1;
    @(posedge clk); #1; irq_req = 1'b0;
    @(negedge clk);
    chk("intr_merge", intr[0], 1);
    bus_cycle(0, T1I, 8'h09, 8'h00, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("irq_vector", rd, 8'h05);
    chk("intr_clear", it, 0);
    bus_cycle(0, T1, 8'h00, 8'h00, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("post_irq_fetch", rd, 8'h06);

    // load/PCW collision and independent same-cycle writes
    bus_cycle(0, T1, 8'h23, 8'hC1, 8'h11, 1, 14'h0123, 8'h22, rd, w, stb, it);
    bus_cycle(0, T1, 8'h23, 8'h41, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("collision_ld_wins", rd, 8'h22);
    bus_cycle(0, T1, 8'h24, 8'hC1, 8'h33, 1, 14'h0125, 8'h44, rd, w, stb, it);
    bus_cycle(0, T1, 8'h24, 8'h41, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("dual_wr_bus", rd, 8'h33);
    bus_cycle(0, T1, 8'h25, 8'h41, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("dual_wr_ld", rd, 8'h44);

    // reset in the last WAIT of a PCW on dut1
    load(14'h0100, 8'h3C);
    @(posedge clk); #1; st[1] = T1;   dout[1] = 8'h00;
    @(posedge clk); #1; st[1] = T2;   dout[1] = 8'hC1;
    @(posedge clk); #1; st[1] = WAIT; dout[1] = 8'hEE;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rst_forces_ready", rdy[1], 0);
    @(posedge clk); #1; st[1] = T3;
    @(negedge clk);
    chk("rst_mid_ready", rdy[1], 0);
    chk("rst_mid_din", din[1], 0);
    @(posedge clk); #1; rst = 1'b0; st[1] = STOPPED; dout[1] = 8'h00;
    bus_cycle(1, T1, 8'h00, 8'h41, 8'h00, 0, 14'h0, 8'h0, rd, w, stb, it);
    chk("rst_no_write", rd, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
